// File: rtl/gray_pool2x2.sv
// gray_pool2x2: 2x2 block averaging of a gray pixel stream into a half-resolution stream
module gray_pool2x2 #(
    parameter int DATA_WIDTH = 8,
    parameter int CAM_WINDOW_WIDTH = 160,
    parameter int CAM_WINDOW_HEIGHT = 120,
    localparam int HW = $clog2(CAM_WINDOW_WIDTH) + 1,
    localparam int OHW = $clog2(CAM_WINDOW_WIDTH / 2) + 1,
    localparam int OVW = $clog2(CAM_WINDOW_HEIGHT / 2) + 1,
    localparam int LB = CAM_WINDOW_WIDTH / 2,
    localparam int IW = $clog2(LB)
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] gray,
    input  logic [HW-1:0]         gray_h_cnt,
    input  logic [HW-1:0]         gray_v_cnt,
    output logic [DATA_WIDTH-1:0] out_gray,
    output logic                  out_valid,
    output logic [OHW-1:0]        out_h_cnt,
    output logic [OVW-1:0]        out_v_cnt,
    output logic                  frame_done
);
    typedef enum logic {WAIT_SOF, ACTIVE} state_t;
    state_t state, state_d;
    logic [DATA_WIDTH-1:0] g0, pr_g;
    logic [HW-1:0] h0, v0, hp, vp, pr_h, pr_v, s1_v, ler;
    logic [HW-2:0] s1_hh;
    logic s0_v, p_v, pr_ok, s1_acc, s1_sof, s1_ok;
    logic acc, sof, proc, pair_hit, even_new, rd_ok;
    logic [DATA_WIDTH:0] sum, s1_sum;
    logic [DATA_WIDTH+1:0] tot;
    logic [IW-1:0] idx;
    logic [LB-1:0] bitmap;
    logic [DATA_WIDTH:0] linebuf [LB];

    always_comb begin
        acc = s0_v && (!p_v || h0 != hp || v0 != vp) &&
              32'(h0) < CAM_WINDOW_WIDTH && 32'(v0) < CAM_WINDOW_HEIGHT;
        sof = acc && h0 == '0 && v0 == '0;
        proc = acc && (state == ACTIVE || sof);
        state_d = sof ? ACTIVE : state;
        pair_hit = proc && h0[0] && pr_ok && pr_h == {h0[HW-1:1], 1'b0} && pr_v == v0;
        sum = {1'b0, pr_g} + {1'b0, g0};
        idx = s1_hh[IW-1:0];
        even_new = s1_acc && !s1_v[0] && (s1_sof || s1_v != ler);
        rd_ok = s1_ok && s1_v[0] && bitmap[idx] && ler == {s1_v[HW-1:1], 1'b0};
        tot = {1'b0, linebuf[idx]} + {1'b0, s1_sum} + (DATA_WIDTH+2)'(2);
    end

    always_ff @(posedge clock)
        if (rst) state <= WAIT_SOF;
        else state <= state_d;

    // S0 input register; p_* holds the previous S0 value for duplicate rejection
    always_ff @(posedge clock) begin
        if (rst) begin
            {g0, h0, v0, hp, vp, s0_v, p_v} <= '0;
        end else begin
            g0 <= gray;
            h0 <= gray_h_cnt;
            v0 <= gray_v_cnt;
            s0_v <= 1'b1;
            hp <= h0;
            vp <= v0;
            p_v <= s0_v;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            {pr_ok, pr_g, pr_h, pr_v} <= '0;
            {s1_acc, s1_sof, s1_ok, s1_hh, s1_v, s1_sum} <= '0;
        end else begin
            if (proc && !h0[0]) begin
                pr_ok <= 1'b1;
                pr_g <= g0;
                pr_h <= h0;
                pr_v <= v0;
            end
            s1_acc <= proc;
            s1_sof <= sof;
            s1_ok <= pair_hit;
            s1_hh <= h0[HW-1:1];
            s1_v <= v0;
            s1_sum <= sum;
        end
    end

    always_ff @(posedge clock)
        if (s1_ok && !s1_v[0]) linebuf[idx] <= s1_sum;

    // the per-index set is placed after the row clear so it wins for that index
    always_ff @(posedge clock) begin
        if (rst) begin
            {bitmap, ler, out_gray, out_valid, out_h_cnt, out_v_cnt, frame_done} <= '0;
        end else begin
            if (even_new) begin
                bitmap <= '0;
                ler <= s1_v;
            end
            if (s1_ok && !s1_v[0]) bitmap[idx] <= 1'b1;
            out_valid <= rd_ok;
            frame_done <= rd_ok && 32'(s1_hh) == CAM_WINDOW_WIDTH / 2 - 1 &&
                          32'(s1_v[HW-1:1]) == CAM_WINDOW_HEIGHT / 2 - 1;
            if (rd_ok) begin
                out_gray <= DATA_WIDTH'(tot >> 2);
                out_h_cnt <= OHW'(s1_hh);
                out_v_cnt <= OVW'(s1_v[HW-1:1]);
            end
        end
    end
endmodule
